atm_session_arbiter: RTL and testbench

Shares one ATM transaction engine (PIN check, deposit, withdrawal, balance datapath) among several card-reader terminals. Grants exclusive sessions round-robin, pulses the engine start, and tracks the session until the owner releases it, the engine reports an error, or an idle timeout expires. Sits between the terminal front-ends and the single ATM controller instance.

---
 rtl/atm_arb_pkg.sv | 18 +
 rtl/atm_rr_picker.sv | 28 ++
 rtl/atm_session_arbiter.sv | 154 +++++++++++++++
 tb/tb_atm_session_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/atm_arb_pkg.sv
// Shared types and defaults for the ATM session arbiter.
package atm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  localparam int DEF_N_TERM  = 4;
  localparam int DEF_TIMEOUT = 200;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/atm_rr_picker.sv
// Combinational round-robin pick: search starts one past ptr and wraps.
module atm_rr_picker #(
  parameter int N_TERM = 4,
  parameter int ID_W   = 2
) (
  input  logic [N_TERM-1:0] req,
  input  logic [ID_W-1:0]   ptr,
  output logic              valid,
  output logic [ID_W-1:0]   idx
);

  int pos;

  // Walk from the farthest candidate back to the nearest so the nearest match wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int i = N_TERM; i >= 1; i--) begin
      pos = (int'(ptr) + i) % N_TERM;
      if (req[pos]) begin
        valid = 1'b1;
        idx   = ID_W'(pos);
      end
    end
  end

endmodule

// File: rtl/atm_session_arbiter.sv
// Grants exclusive ATM engine sessions to terminals round-robin.
// Idle timeout is built only when ATM_ARB_TIMEOUT_EN is defined.
//
//   state      | meaning
//   IDLE       | no session, arbitrate pending requests
//   GRANT      | drive grant and start pulse, clear timeout counter
//   ACTIVE     | session running, watch release / error / timeout
//   RELEASE    | drop grant, report end reason, move rr pointer
module atm_session_arbiter
  import atm_arb_pkg::*;
#(
  parameter int N_TERM  = DEF_N_TERM,
  parameter int ID_W    = id_width(N_TERM),
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_TERM-1:0] req,
  input  logic [N_TERM-1:0] release_req,
  input  logic              eng_done,
  input  logic              eng_error,
  output logic [N_TERM-1:0] grant,
  output logic [ID_W-1:0]   owner_id,
  output logic              busy,
  output logic              eng_start,
  output logic              timeout_evt,
  output logic              abort_evt
);

  arb_state_e        state, state_nx;
  logic [ID_W-1:0]   ptr, ptr_nx, owner_nx, pick_idx;
  logic              pick_valid;
  logic [N_TERM-1:0] grant_nx;
  logic              busy_nx, eng_start_nx, abort_evt_nx;
  logic              end_abort, end_abort_nx;
`ifdef ATM_ARB_TIMEOUT_EN
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              end_timeout, end_timeout_nx, timeout_evt_nx, timeout_hit;
`else
  logic              unused_timeout_cfg;
  // Without the timeout, eng_done has nothing to reset.
  assign unused_timeout_cfg = eng_done | (TIMEOUT < 0) | (CNT_W < 0);
  assign timeout_evt        = 1'b0;
`endif

  atm_rr_picker #(.N_TERM(N_TERM), .ID_W(ID_W)) u_picker (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_nx     = state;
    ptr_nx       = ptr;
    owner_nx     = owner_id;
    grant_nx     = grant;
    busy_nx      = busy;
    eng_start_nx = 1'b0;
    abort_evt_nx = 1'b0;
    end_abort_nx = end_abort;
`ifdef ATM_ARB_TIMEOUT_EN
    cnt_nx         = cnt;
    end_timeout_nx = end_timeout;
    timeout_evt_nx = 1'b0;
    timeout_hit    = (cnt == CNT_W'(TIMEOUT - 1)) && !eng_done;
`endif
    case (state)
      ST_IDLE: begin
        grant_nx = '0;
        busy_nx  = 1'b0;
        if (pick_valid) begin
          owner_nx = pick_idx;
          state_nx = ST_GRANT;
        end
      end
      ST_GRANT: begin
        grant_nx     = N_TERM'(1) << owner_id;
        busy_nx      = 1'b1;
        eng_start_nx = 1'b1;
        end_abort_nx = 1'b0;
`ifdef ATM_ARB_TIMEOUT_EN
        cnt_nx         = '0;
        end_timeout_nx = 1'b0;
`endif
        state_nx = ST_ACTIVE;
      end
      ST_ACTIVE: begin
`ifdef ATM_ARB_TIMEOUT_EN
        cnt_nx = cnt + 1'b1;
`endif
        if (release_req[owner_id]) begin
          state_nx = ST_RELEASE;
        end else if (eng_error) begin
          end_abort_nx = 1'b1;
          state_nx     = ST_RELEASE;
        end
`ifdef ATM_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          end_timeout_nx = 1'b1;
          state_nx       = ST_RELEASE;
        end else if (eng_done) begin
          cnt_nx = '0;
        end
`endif
      end
      ST_RELEASE: begin
        grant_nx     = '0;
        busy_nx      = 1'b1;
        ptr_nx       = owner_id;
        abort_evt_nx = end_abort;
`ifdef ATM_ARB_TIMEOUT_EN
        timeout_evt_nx = end_timeout;
`endif
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= ID_W'(N_TERM - 1);
      owner_id  <= '0;
      grant     <= '0;
      busy      <= 1'b0;
      eng_start <= 1'b0;
      abort_evt <= 1'b0;
      end_abort <= 1'b0;
`ifdef ATM_ARB_TIMEOUT_EN
      cnt         <= '0;
      end_timeout <= 1'b0;
      timeout_evt <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      owner_id  <= owner_nx;
      grant     <= grant_nx;
      busy      <= busy_nx;
      eng_start <= eng_start_nx;
      abort_evt <= abort_evt_nx;
      end_abort <= end_abort_nx;
`ifdef ATM_ARB_TIMEOUT_EN
      cnt         <= cnt_nx;
      end_timeout <= end_timeout_nx;
      timeout_evt <= timeout_evt_nx;
`endif
    end
  end

endmodule

// File: tb/tb_atm_session_arbiter.sv
// Scoreboard bench for atm_session_arbiter; follows ATM_ARB_TIMEOUT_EN if defined.
module tb_atm_session_arbiter;

  localparam int N = 4;
  localparam int T = 10;
`ifdef ATM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req, release_req;
  logic         eng_done, eng_error;
  logic [N-1:0] grant;
  logic [1:0]   owner_id;
  logic         busy, eng_start, timeout_evt, abort_evt;

  always #5 clk = ~clk;

  atm_session_arbiter #(.N_TERM(N), .ID_W(2), .TIMEOUT(T), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .release_req (release_req),
    .eng_done    (eng_done),
    .eng_error   (eng_error),
    .grant       (grant),
    .owner_id    (owner_id),
    .busy        (busy),
    .eng_start   (eng_start),
    .timeout_evt (timeout_evt),
    .abort_evt   (abort_evt)
  );

  typedef struct {int owner;} start_t;
  typedef struct {int owner; int len; bit to; bit ab;} end_t;

  start_t start_q[$];
  end_t   end_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: sessions as events on an edge counter.
  int edge_n = 0;
  bit m_in = 1'b0;
  int m_ptr = N - 1, m_owner = 0, m_start = 0, m_last_clear = 0, m_next_arb = 0;

  function automatic int rr_pick(input int p, input logic [N-1:0] r);
    for (int i = 1; i <= N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic model_step();
    int age;
    bit fin, to, ab;
    end_t e;
    edge_n++;
    if (rst) begin
      m_in = 1'b0;
      m_ptr = N - 1;
      m_next_arb = edge_n + 1;
      start_q.delete();
      end_q.delete();
      return;
    end
    if (!m_in) begin
      if (edge_n >= m_next_arb && req != '0) begin
        m_owner = rr_pick(m_ptr, req);
        m_in = 1'b1;
        m_start = edge_n;
        m_last_clear = edge_n + 1;
        start_q.push_back('{owner: m_owner});
      end
    end else if (edge_n >= m_start + 2) begin
      age = edge_n - m_last_clear - 1;
      fin = 1'b0; to = 1'b0; ab = 1'b0;
      if (release_req[m_owner]) fin = 1'b1;
      else if (eng_error) begin fin = 1'b1; ab = 1'b1; end
      else if (TO_EN && age == T - 1 && !eng_done) begin fin = 1'b1; to = 1'b1; end
      else if (eng_done) m_last_clear = edge_n;
      if (fin) begin
        e = '{owner: m_owner, len: edge_n - m_start, to: to, ab: ab};
        end_q.push_back(e);
        m_ptr = m_owner;
        m_in = 1'b0;
        m_next_arb = edge_n + 2;
      end
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] rl, input logic d, input logic er);
    req = r; release_req = rl; eng_done = d; eng_error = er;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Monitor: pops expectations whenever a session starts or ends.
  int cyc = 0, start_cyc = 0;
  bit chk_idle = 1'b0;
  always @(negedge clk) begin
    start_t s;
    end_t e;
    cyc++;
    if (eng_start) begin
      if (start_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL start_unexpected actual=grant %0h required=no session start", grant);
      end else begin
        s = start_q.pop_front();
        check("start_grant", grant, 32'(1) << s.owner);
        check("start_owner", owner_id, s.owner);
        check("start_busy", busy, 1);
        start_cyc = cyc;
      end
    end
    if (busy && grant == '0) begin
      if (end_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL end_unexpected actual=owner %0d required=no session end", owner_id);
      end else begin
        e = end_q.pop_front();
        check("end_owner", owner_id, e.owner);
        check("end_len", cyc - start_cyc, e.len);
        check("end_timeout_evt", timeout_evt, e.to);
        check("end_abort_evt", abort_evt, e.ab);
      end
      chk_idle = 1'b1;
    end else begin
      check("evt_outside_release", {timeout_evt, abort_evt}, 0);
      if (chk_idle) begin
        check("busy_after_release", {busy, grant}, 0);
        chk_idle = 1'b0;
      end
    end
  end

  initial begin
    rst = 1'b1; req = '0; release_req = '0; eng_done = 1'b0; eng_error = 1'b0;
    @(negedge clk);
    repeat (3) step('0, '0, 0, 0);
    check("rst_grant", grant, 0);
    check("rst_owner", owner_id, 0);
    check("rst_busy", busy, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_timeout_evt", timeout_evt, 0);
    check("rst_abort_evt", abort_evt, 0);
    rst = 1'b0;

    // First arbitration, then release by owner 1 with 0101 pending.
    repeat (5) step(4'b0110, '0, 0, 0);
    step(4'b0101, 4'b0010, 0, 0);
    repeat (6) step(4'b0101, '0, 0, 0);
    step('0, 4'b0100, 0, 0);
    repeat (3) step('0, '0, 0, 0);

    // Idle session left to time out.
    step(4'b0001, '0, 0, 0);
    repeat (14) step('0, '0, 0, 0);
    step('0, 4'b1111, 0, 0);
    repeat (3) step('0, '0, 0, 0);

    // Periodic eng_done keeps the session alive.
    step(4'b1000, '0, 0, 0);
    for (int i = 0; i < 32; i++) step('0, '0, (i % 8) == 7, 0);
    step('0, 4'b1000, 0, 0);
    repeat (3) step('0, '0, 0, 0);

    // Engine error, with a coincident eng_done.
    step(4'b0010, '0, 0, 0);
    repeat (4) step('0, '0, 0, 0);
    step('0, '0, 1, 1);
    repeat (4) step('0, '0, 0, 0);

    // Reset in ACTIVE, then terminal 3 alone.
    repeat (5) step(4'b0001, '0, 0, 0);
    rst = 1'b1;
    step(4'b0001, '0, 0, 0);
    check("midrst_grant", grant, 0);
    check("midrst_busy", busy, 0);
    rst = 1'b0;
    repeat (4) step(4'b1000, '0, 0, 0);
    step('0, 4'b1000, 0, 0);
    repeat (3) step('0, '0, 0, 0);

    // Randomized traffic.
    for (int b = 0; b < 600; b++) begin
      logic [N-1:0] r;
      int hold;
      r = N'($urandom);
      hold = $urandom_range(1, 6);
      for (int j = 0; j < hold; j++)
        step(r, ($urandom_range(0, 9) == 0) ? N'($urandom) : '0,
             $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0);
    end

    repeat (6) step('0, '1, 0, 0);
    check("drain_start_q", start_q.size(), 0);
    check("drain_end_q", end_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
